exec_mdu: RTL and testbench

EXEC_MDU -- requirements
Module: exec_mdu

---
 rtl/exec_mdu.sv | 223 ++++++++++++++++++++++
 tb/tb_exec_mdu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_mdu.sv
// Multiply/divide execution unit: pipelined-latency multiplier plus restoring divider.
// The divider is only built when EXEC_MDU_DIV_EN is defined; otherwise commands 1xx return 0 in cycle 1.
module exec_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic [2:0]       command,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [4:0]       rd_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data,
    output logic [4:0]       rd_out,
    output logic [2:0]       wselector
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [1:0]         op_cmd;
    logic [4:0]         op_rd;

    logic [WIDTH-1:0]   mul_x;
    logic [WIDTH-1:0]   mul_y;
    logic [1:0]         mul_cmd;
    logic               mul_sgn;
    logic signed [2*WIDTH-1:0] mul_xe;
    logic signed [2*WIDTH-1:0] mul_ye;
    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mul_res;

    logic               is_mul;
    logic               imm_fast;
    logic [WIDTH-1:0]   imm_data;

`ifdef EXEC_MDU_DIV_EN
    logic               div_sgn;
    logic               div_rem;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [WIDTH-1:0]   dq;
    logic [WIDTH-1:0]   dr;
    logic [WIDTH-1:0]   dd;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   fix_q;
    logic [WIDTH-1:0]   fix_r;
`endif

    // A single multiplier: fed straight from the ports when idle (single-stage case), else from the latched operands.
    always_comb begin
        mul_x   = (state == IDLE) ? rs : op_a;
        mul_y   = (state == IDLE) ? rt : op_b;
        mul_cmd = (state == IDLE) ? command[1:0] : op_cmd;
        mul_sgn = (mul_cmd == 2'b01);
        mul_xe  = {{WIDTH{mul_sgn & mul_x[WIDTH-1]}}, mul_x};
        mul_ye  = {{WIDTH{mul_sgn & mul_y[WIDTH-1]}}, mul_y};
        prod    = mul_xe * mul_ye;
        mul_res = (mul_cmd == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end

    // Commands that finish in the cycle after acceptance, with their result.
    always_comb begin
        is_mul   = ~command[2] & (command[1:0] != 2'b11);
        imm_fast = 1'b1;
        imm_data = '0;
`ifdef EXEC_MDU_DIV_EN
        div_sgn  = ~command[0];
        div_rem  = command[1];
        rs_mag   = (div_sgn & rs[WIDTH-1]) ? -rs : rs;
        rt_mag   = (div_sgn & rt[WIDTH-1]) ? -rt : rt;
`endif
        if (is_mul) begin
            imm_fast = (MUL_STAGES == 1);
            imm_data = mul_res;
        end
`ifdef EXEC_MDU_DIV_EN
        else if (command[2]) begin
            if (rt == '0)
                imm_data = div_rem ? rs : '1;
            else if (div_sgn && rs == {1'b1, {(WIDTH-1){1'b0}}} && rt == '1)
                imm_data = div_rem ? '0 : rs;
            else
                imm_fast = 1'b0;
        end
`endif
    end

`ifdef EXEC_MDU_DIV_EN
    always_comb begin
        shifted = {dr, dq[WIDTH-1]};
        trial   = shifted - {1'b0, dd};
        fix_q   = neg_q ? -dq : dq;
        fix_r   = neg_r ? -dr : dr;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cmd    <= '0;
            op_rd     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            data      <= '0;
            rd_out    <= '0;
            wselector <= 3'b000;
`ifdef EXEC_MDU_DIV_EN
            dq        <= '0;
            dr        <= '0;
            dd        <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (enable && !flush) begin
                        busy   <= 1'b1;
                        op_a   <= rs;
                        op_b   <= rt;
                        op_cmd <= command[1:0];
                        op_rd  <= rd_in;
                        if (imm_fast) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            wselector <= 3'b010;
                            data      <= imm_data;
                            rd_out    <= rd_in;
                        end else if (is_mul) begin
                            state <= MUL;
                            cnt   <= CW'(MUL_STAGES - 2);
                        end
`ifdef EXEC_MDU_DIV_EN
                        else begin
                            state <= DIV;
                            cnt   <= CW'(WIDTH - 1);
                            dq    <= rs_mag;
                            dd    <= rt_mag;
                            dr    <= '0;
                            neg_q <= div_sgn & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                            neg_r <= div_sgn & rs[WIDTH-1];
                        end
`endif
                    end
                end
                MUL: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        wselector <= 3'b010;
                        data      <= mul_res;
                        rd_out    <= op_rd;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
`ifdef EXEC_MDU_DIV_EN
                // One restoring step per cycle: keep the trial difference when it did not borrow.
                DIV: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (!trial[WIDTH]) begin
                            dr <= trial[WIDTH-1:0];
                            dq <= {dq[WIDTH-2:0], 1'b1};
                        end else begin
                            dr <= shifted[WIDTH-1:0];
                            dq <= {dq[WIDTH-2:0], 1'b0};
                        end
                        if (cnt == '0)
                            state <= FIX;
                        else
                            cnt <= cnt - CW'(1);
                    end
                end
                FIX: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state     <= DONE;
                        done      <= 1'b1;
                        wselector <= 3'b010;
                        data      <= op_cmd[1] ? fix_r : fix_q;
                        rd_out    <= op_rd;
                    end
                end
`endif
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    wselector <= 3'b000;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_mdu.sv
// Directed self-checking bench for exec_mdu (WIDTH=32, MUL_STAGES=2); divider cases follow EXEC_MDU_DIV_EN.
module tb_exec_mdu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [2:0]  command;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] data;
    logic [4:0]  rd_out;
    logic [2:0]  wselector;

    int total  = 0;
    int passed = 0;

    exec_mdu #(.WIDTH(32), .MUL_STAGES(2)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .command(command),
        .rs(rs), .rt(rt), .rd_in(rd_in), .flush(flush),
        .busy(busy), .done(done), .data(data), .rd_out(rd_out), .wselector(wselector)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Called at a negedge of cycle 0; returns at the negedge of cycle 1.
    task automatic start_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] r);
        command = c; rs = a; rt = b; rd_in = r; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    // Returns the cycle in which done was seen, or -1 if not within limit.
    task automatic wait_done(input int limit, output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; enable = 1'b0; flush = 1'b0; command = '0; rs = '0; rt = '0; rd_in = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, wselector, rd_out} !== 10'b0) $display("[TB] FAIL reset_ctrl: got busy=%b done=%b wsel=%b rd=%0d, want all 0", busy, done, wselector, rd_out);
        else passed++;
        total++;
        if (data !== 32'h0) $display("[TB] FAIL reset_data: got %h want 00000000", data);
        else passed++;
        rstn = 1'b1;
    endtask

    task automatic test_mul;
        int cyc;
        logic [2:0]  vc [0:6];
        logic [31:0] va [0:6];
        logic [31:0] vb [0:6];
        logic [31:0] ve [0:6];
        vc = '{3'b001, 3'b010, 3'b000, 3'b001, 3'b010, 3'b001, 3'b010};
        va = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF};
        vb = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'h0000_0002};
        ve = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0006, 32'h4000_0000, 32'h0000_0001};
        start_op(3'b000, 32'h0001_0003, 32'h0000_0005, 5'd7);
        total++;
        if ({busy, done} !== 2'b10) $display("[TB] FAIL mul_cycle1: got busy=%b done=%b want busy=1 done=0", busy, done);
        else passed++;
        wait_done(10, cyc);
        total++;
        if (cyc != 2 || data !== 32'h0005_000F) $display("[TB] FAIL mul_basic: got cycle %0d data %h want cycle 2 data 0005000f", cyc, data);
        else passed++;
        total++;
        if ({rd_out, wselector, busy} !== {5'd7, 3'b010, 1'b1}) $display("[TB] FAIL mul_done_ctrl: got rd=%0d wsel=%b busy=%b want 7 010 1", rd_out, wselector, busy);
        else passed++;
        @(negedge clk);
        total++;
        if ({done, busy, wselector} !== 5'b0 || data !== 32'h0005_000F) $display("[TB] FAIL mul_after: got done=%b busy=%b wsel=%b data=%h want 0 0 000 0005000f", done, busy, wselector, data);
        else passed++;
        for (int i = 0; i < 7; i++) begin
            start_op(vc[i], va[i], vb[i], 5'(i + 1));
            wait_done(10, cyc);
            total++;
            if (cyc != 2 || data !== ve[i] || rd_out !== 5'(i + 1)) $display("[TB] FAIL mul_vec%0d: got cycle %0d data %h rd %0d want cycle 2 data %h rd %0d", i, cyc, data, rd_out, ve[i], i + 1);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_reserved;
        int cyc;
        start_op(3'b011, 32'd5, 32'd6, 5'd9);
        wait_done(10, cyc);
        total++;
        if (cyc != 1 || data !== 32'h0 || rd_out !== 5'd9) $display("[TB] FAIL reserved: got cycle %0d data %h rd %0d want cycle 1 data 0 rd 9", cyc, data, rd_out);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_enable_busy;
        start_op(3'b000, 32'd2, 32'd3, 5'd4);
        command = 3'b000; rs = 32'd4; rt = 32'd5; rd_in = 5'd11; enable = 1'b1;
        @(negedge clk);
        total++;
        if (done !== 1'b1 || data !== 32'd6 || rd_out !== 5'd4) $display("[TB] FAIL enable_busy: got done=%b data=%h rd=%0d want 1 00000006 4", done, data, rd_out);
        else passed++;
        @(negedge clk);
        enable = 1'b0;
        total++;
        if ({busy, done} !== 2'b00) $display("[TB] FAIL enable_in_done: got busy=%b done=%b want 0 0", busy, done);
        else passed++;
        @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00 || data !== 32'd6) $display("[TB] FAIL enable_in_done_late: got busy=%b done=%b data=%h want 0 0 00000006", busy, done, data);
        else passed++;
    endtask

    task automatic test_flush;
        int cyc;
        int seen;
        start_op(3'b000, 32'd6, 32'd7, 5'd12);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if ({busy, done} !== 2'b00 || data !== 32'd6 || rd_out !== 5'd4) $display("[TB] FAIL flush_mul: got busy=%b done=%b data=%h rd=%0d want 0 0 00000006 4", busy, done, data, rd_out);
        else passed++;
        command = 3'b000; rs = 32'd2; rt = 32'd2; rd_in = 5'd1; enable = 1'b1; flush = 1'b1;
        @(negedge clk);
        enable = 1'b0; flush = 1'b0;
        total++;
        if ({busy, done} !== 2'b00) $display("[TB] FAIL flush_enable: got busy=%b done=%b want 0 0", busy, done);
        else passed++;
        start_op(3'b000, 32'd5, 32'd9, 5'd13);
        wait_done(10, cyc);
        flush = 1'b1;
        total++;
        if (cyc != 2 || data !== 32'd45) $display("[TB] FAIL flush_done_cycle: got cycle %0d data %h want cycle 2 data 0000002d", cyc, data);
        else passed++;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if ({busy, done} !== 2'b00 || data !== 32'd45 || rd_out !== 5'd13) $display("[TB] FAIL flush_after_done: got busy=%b done=%b data=%h rd=%0d want 0 0 0000002d 13", busy, done, data, rd_out);
        else passed++;
`ifdef EXEC_MDU_DIV_EN
        start_op(3'b101, 32'd1000, 32'd3, 5'd20);
        seen = 0;
        repeat (9) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if ({busy, done} !== 2'b00 || data !== 32'd45 || seen != 0) $display("[TB] FAIL flush_div: got busy=%b done=%b data=%h early_done=%0d want 0 0 0000002d 0", busy, done, data, seen);
        else passed++;
        start_op(3'b000, 32'd6, 32'd7, 5'd14);
        wait_done(10, cyc);
        total++;
        if (cyc != 2 || data !== 32'd42 || rd_out !== 5'd14) $display("[TB] FAIL flush_div_mul: got cycle %0d data %h rd %0d want cycle 2 data 0000002a rd 14", cyc, data, rd_out);
        else passed++;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        total++;
        if (seen != 0) $display("[TB] FAIL flush_div_stray: got %0d done pulses want 0", seen);
        else passed++;
`endif
    endtask

    task automatic test_div;
        int cyc;
`ifdef EXEC_MDU_DIV_EN
        logic [2:0]  vc [0:9];
        logic [31:0] va [0:9];
        logic [31:0] vb [0:9];
        logic [31:0] ve [0:9];
        int          vt [0:9];
        vc = '{3'b100, 3'b110, 3'b101, 3'b100, 3'b110, 3'b111, 3'b100, 3'b110, 3'b110, 3'b101};
        va = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'h8000_0000, 32'd100, 32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FFFF};
        vb = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd0, 32'd1};
        ve = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'd2, 32'hFFFF_FFF2, 32'd2, 32'hFFFF_FF9C, 32'hFFFF_FFFF};
        vt = '{34, 34, 1, 1, 1, 34, 34, 34, 1, 34};
        for (int i = 0; i < 10; i++) begin
`else
        logic [2:0]  vc [0:1];
        logic [31:0] va [0:1];
        logic [31:0] vb [0:1];
        logic [31:0] ve [0:1];
        int          vt [0:1];
        vc = '{3'b101, 3'b110};
        va = '{32'd9, 32'd9};
        vb = '{32'd3, 32'd3};
        ve = '{32'd0, 32'd0};
        vt = '{1, 1};
        for (int i = 0; i < 2; i++) begin
`endif
            start_op(vc[i], va[i], vb[i], 5'(i + 16));
            wait_done(40, cyc);
            total++;
            if (cyc != vt[i] || data !== ve[i] || rd_out !== 5'(i + 16)) $display("[TB] FAIL div_vec%0d: got cycle %0d data %h rd %0d want cycle %0d data %h rd %0d", i, cyc, data, rd_out, vt[i], ve[i], i + 16);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
`ifdef EXEC_MDU_DIV_EN
        start_op(3'b101, 32'd1000, 32'd3, 5'd15);
        repeat (4) @(negedge clk);
`else
        start_op(3'b000, 32'd6, 32'd7, 5'd15);
`endif
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        total++;
        if ({busy, done} !== 2'b00 || data !== 32'h0 || rd_out !== 5'd0) $display("[TB] FAIL reset_mid: got busy=%b done=%b data=%h rd=%0d want 0 0 0 0", busy, done, data, rd_out);
        else passed++;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen != 0) $display("[TB] FAIL reset_mid_stray: got %0d busy/done cycles want 0", seen);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_mul;
        test_reserved;
        test_enable_busy;
        test_flush;
        test_div;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
